// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the single-byte I2C master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam int unsigned c_clk_div_default = 4;

  // Nine protocol states need four bits of encoding.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_ADDR  = 4'd2,
    ST_ACK1  = 4'd3,
    ST_WDATA = 4'd4,
    ST_ACK2  = 4'd5,
    ST_RDATA = 4'd6,
    ST_MACK  = 4'd7,
    ST_STOP  = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_e;

  function automatic logic is_byte_state(input state_e s);
    return (s == ST_ADDR) || (s == ST_WDATA) || (s == ST_RDATA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_clk_div.sv
// ============================================================================
// Module      : i2c_clk_div
// Description : Quarter-phase timebase; tick marks the last cycle of a quarter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_clk_div
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = c_clk_div_default
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     run,
  output logic     tick,
  output quarter_e quarter
);

  localparam logic [7:0] c_cnt_last = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  quarter_e   r_quarter;

  assign tick    = run && (r_cnt == c_cnt_last);
  assign quarter = r_quarter;

  // Held at zero while idle so every transaction starts at quarter 0, cycle 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 8'd0;
      r_quarter <= Q0;
    end else if (!run) begin
      r_cnt     <= 8'd0;
      r_quarter <= Q0;
    end else if (tick) begin
      r_cnt     <= 8'd0;
      r_quarter <= quarter_e'(r_quarter + 2'd1);
    end else begin
      r_cnt     <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_master.sv
// ============================================================================
// Module      : i2c_master
// Description : Single-byte I2C master (write or read), fixed 20-bit-period frame.
//               Define I2C_MASTER_ACKCHK_EN to abort to STOP on slave NACK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = c_clk_div_default
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       en,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       scl,
  output logic       sda_o,
  output logic       sda_oe,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [7:0] r_rdata;
  logic [7:0] r_wdata;
  logic       r_en;

  logic       w_run;
  logic       w_tick;
  quarter_e   w_quarter;
  logic       w_bit_end;
  logic       w_sample;
  logic       w_accept;
  logic       w_last_bit;

  assign w_run      = (r_state != ST_IDLE);
  assign w_bit_end  = w_tick && (w_quarter == Q3);
  assign w_sample   = w_tick && (w_quarter == Q2);
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_last_bit = (r_bit_cnt == 3'd7);

  i2c_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_run),
    .tick    (w_tick),
    .quarter (w_quarter)
  );

`ifdef I2C_MASTER_ACKCHK_EN
  logic r_nack;
  logic r_ack_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nack    <= 1'b0;
      r_ack_err <= 1'b0;
    end else if (w_accept) begin
      r_nack    <= 1'b0;
      r_ack_err <= 1'b0;
    end else if (w_sample && (r_state inside {ST_ACK1, ST_ACK2})) begin
      r_nack <= sda_i;
      if (sda_i) r_ack_err <= 1'b1;
    end
  end

  assign ack_err = r_ack_err;
`else
  assign ack_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_START;
      ST_START: if (w_bit_end) w_state_nxt = ST_ADDR;
      ST_ADDR:  if (w_bit_end && w_last_bit) w_state_nxt = ST_ACK1;
      ST_ACK1: begin
        if (w_bit_end) begin
`ifdef I2C_MASTER_ACKCHK_EN
          if (r_nack)    w_state_nxt = ST_STOP;
          else if (r_en) w_state_nxt = ST_WDATA;
          else           w_state_nxt = ST_RDATA;
`else
          w_state_nxt = r_en ? ST_WDATA : ST_RDATA;
`endif
        end
      end
      ST_WDATA: if (w_bit_end && w_last_bit) w_state_nxt = ST_ACK2;
      ST_ACK2:  if (w_bit_end) w_state_nxt = ST_STOP;
      ST_RDATA: if (w_bit_end && w_last_bit) w_state_nxt = ST_MACK;
      ST_MACK:  if (w_bit_end) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_bit_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode from registered state, so SDA moves only when the state
  // or shift register changes on a bit boundary (START/STOP excepted).
  always_comb begin
    scl    = 1'b1;
    sda_o  = 1'b1;
    sda_oe = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_START: begin
        sda_oe = 1'b1;
        sda_o  = (w_quarter inside {Q0, Q1});
      end
      ST_ADDR, ST_WDATA: begin
        scl    = (w_quarter inside {Q2, Q3});
        sda_oe = 1'b1;
        sda_o  = r_tx[7];
      end
      ST_STOP: begin
        scl = (w_quarter inside {Q2, Q3});
        if (w_quarter inside {Q0, Q1}) begin
          sda_oe = 1'b1;
          sda_o  = 1'b0;
        end
        done = w_bit_end;
      end
      default: scl = (w_quarter inside {Q2, Q3});
    endcase
  end

  assign busy  = w_run;
  assign rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
      r_rdata   <= 8'd0;
      r_wdata   <= 8'd0;
      r_en      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_tx      <= {addr, ~en};
        r_wdata   <= wdata;
        r_en      <= en;
        r_bit_cnt <= 3'd0;
      end
      if (w_sample && (r_state == ST_RDATA)) r_rx <= {r_rx[6:0], sda_i};
      if (w_bit_end) begin
        r_bit_cnt <= is_byte_state(r_state) ? r_bit_cnt + 3'd1 : 3'd0;
        if (r_state inside {ST_ADDR, ST_WDATA}) r_tx <= {r_tx[6:0], 1'b0};
        if (r_state == ST_ACK1)                 r_tx <= r_wdata;
        if ((r_state == ST_RDATA) && w_last_bit) r_rdata <= r_rx;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master.sv
// ============================================================================
// Module      : tb_i2c_master
// Description : Directed-vector bench for i2c_master with a simple slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_master;

  localparam int unsigned CD = 2;
  localparam int BP = 4 * CD;
`ifdef I2C_MASTER_ACKCHK_EN
  localparam bit ACKCHK = 1'b1;
`else
  localparam bit ACKCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic       slave_val = 1'b1;
  logic       sda_i;
  logic       scl, sda_o, sda_oe, busy, done, ack_err;
  logic [7:0] rdata;

  assign sda_i = (sda_oe ? sda_o : 1'b1) & slave_val;

  i2c_master #(.CLK_DIV(CD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .en     (en),
    .addr   (addr),
    .wdata  (wdata),
    .sda_i  (sda_i),
    .scl    (scl),
    .sda_o  (sda_o),
    .sda_oe (sda_oe),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-transaction observations
  logic       cap [0:31];
  int         ncap;
  int         done_cyc;
  logic       err_d;
  logic [7:0] rd_d;
  logic       rel_oe;
  logic [1:0] b10;
  logic [2:0] st_q1, st_q2;
  logic       busy1;
  logic [1:0] post;

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] v;
    v = 8'd0;
    for (int i = 0; i < 8; i++) v = {v[6:0], cap[base + i]};
    return v;
  endfunction

  task automatic run_txn(input logic t_en, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                         input logic [7:0] t_sbyte, input logic t_nack1, input logic t_nack2,
                         input logic t_hold);
    int   n, b;
    logic prev_scl, line;
    en = t_en; addr = t_addr; wdata = t_wdata; start = 1'b1;
    ncap = 0; done_cyc = 0; rel_oe = 1'b0; b10 = 2'b00; st_q1 = 3'b000; st_q2 = 3'b000;
    busy1 = 1'b0; err_d = 1'b0; rd_d = 8'd0;
    @(posedge clk);
    #1;
    if (!t_hold) start = 1'b0;
    prev_scl = 1'b1;
    n = 1;
    forever begin
      b = (n - 1) / BP;
      slave_val = 1'b1;
      if (b == 9 && !t_nack1) slave_val = 1'b0;
      if (b == 18 && t_en && !t_nack2) slave_val = 1'b0;
      if (!t_en && b >= 10 && b <= 17) slave_val = t_sbyte[17 - b];
      line = (sda_oe ? sda_o : 1'b1) & slave_val;
      if (n == 1) busy1 = busy;
      if (n == 3) st_q1 = {scl, sda_oe, sda_o};
      if (n == 5) st_q2 = {scl, sda_oe, sda_o};
      if (n == 10 * BP + 1) b10 = {sda_oe, sda_o};
      if ((b == 9 || b == 18) && sda_oe) rel_oe = 1'b1;
      if (scl && !prev_scl && ncap < 32) begin
        cap[ncap] = line;
        ncap++;
      end
      prev_scl = scl;
      if (done) begin
        done_cyc = n; err_d = ack_err; rd_d = rdata;
        break;
      end
      if (n >= 1000) break;
      n++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    post = {done, busy};
    slave_val = 1'b1;
  endtask

  typedef struct {
    logic       en;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] sbyte;
    logic       nack1;
    logic       nack2;
    logic [7:0] exp_abyte;
    logic [7:0] exp_dbyte;
    logic       chk_data;
    int         exp_done;
    logic       exp_err;
    logic [7:0] exp_rd;
    logic [1:0] exp_b10;
  } vec_t;

  vec_t vecs [7];

  task automatic check_common(input string tag, input int exp_done);
    check({tag, " done_cycle"}, done_cyc, exp_done);
    check({tag, " busy_first"}, 32'(busy1), 32'd1);
    check({tag, " start_q1"}, 32'(st_q1), 32'h7);
    check({tag, " start_q2"}, 32'(st_q2), 32'h6);
    check({tag, " after_done"}, 32'(post), 32'h0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 7'h50, 8'hA5, 8'h00, 1'b0, 1'b0, 8'hA0, 8'hA5, 1'b1, 160, 1'b0, 8'h00, 2'b11};
    vecs[1] = '{1'b0, 7'h50, 8'h00, 8'h3C, 1'b0, 1'b0, 8'hA1, 8'h3C, 1'b1, 160, 1'b0, 8'h3C, 2'b01};
    vecs[2] = '{1'b1, 7'h7F, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b1, 160, 1'b0, 8'h3C, 2'b10};
    vecs[3] = '{1'b0, 7'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h03, 8'hFF, 1'b1, 160, 1'b0, 8'hFF, 2'b01};
    vecs[4] = '{1'b0, 7'h2A, 8'h00, 8'h81, 1'b0, 1'b0, 8'h55, 8'h81, 1'b1, 160, 1'b0, 8'h81, 2'b01};
    vecs[5] = '{1'b1, 7'h12, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h24, 8'hFF, !ACKCHK,
                ACKCHK ? 88 : 160, ACKCHK, 8'h81, ACKCHK ? 2'b10 : 2'b11};
    vecs[6] = '{1'b1, 7'h33, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h66, 8'h5A, 1'b1, 160, ACKCHK, 8'h81, 2'b10};

    #1;
    check("reset_outputs", {23'd0, scl, sda_o, sda_oe, busy, done, ack_err, rdata},
          {23'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_txn(vecs[i].en, vecs[i].addr, vecs[i].wdata, vecs[i].sbyte,
              vecs[i].nack1, vecs[i].nack2, 1'b0);
      check_common(tag, vecs[i].exp_done);
      check({tag, " addr_byte"}, 32'(get_byte(0)), 32'(vecs[i].exp_abyte));
      if (vecs[i].chk_data)
        check({tag, " data_byte"}, 32'(get_byte(9)), 32'(vecs[i].exp_dbyte));
      check({tag, " ack_err"}, 32'(err_d), 32'(vecs[i].exp_err));
      check({tag, " rdata"}, 32'(rd_d), 32'(vecs[i].exp_rd));
      check({tag, " bit10_sda"}, 32'(b10), 32'(vecs[i].exp_b10));
      check({tag, " ack_released"}, 32'(rel_oe), 32'd0);
    end

    // Reset in the middle of address bit 4 (bit period 5, quarter 1)
    en = 1'b1; addr = 7'h50; wdata = 8'hA5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (43) @(posedge clk);
    #1;
    check("pre_reset_scl_sda", {29'd0, scl, sda_oe, sda_o}, 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {28'd0, scl, sda_oe, busy, done}, 32'h8);
    check("mid_reset_rdata", 32'(rdata), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 7'h50, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
    check_common("post_reset", 160);
    check("post_reset addr_byte", 32'(get_byte(0)), 32'hA0);

    // start held high through done: one frame, then a new one from IDLE
    run_txn(1'b1, 7'h50, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);
    check_common("held1", 160);
    run_txn(1'b1, 7'h21, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0);
    check_common("held2", 160);
    check("held2 addr_byte", 32'(get_byte(0)), 32'h42);
    check("held2 data_byte", 32'(get_byte(9)), 32'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
